// File: rtl/bus040_pkg.sv
// Shared definitions for the 68040-style local bus initiator: SIZ codes, FSM states,
// default timing limits and small helpers used by the initiator and its watchdog.
package bus040_pkg;

    // Bus SIZ encodings
    localparam logic [1:0] SIZ_LONG = 2'b00;
    localparam logic [1:0] SIZ_BYTE = 2'b01;
    localparam logic [1:0] SIZ_WORD = 2'b10;
    localparam logic [1:0] SIZ_LINE = 2'b11;

    // Default watchdog limit and retry budget
    localparam int unsigned TIMEOUT_CYC_DEF = 256;
    localparam int unsigned RETRY_MAX_DEF   = 3;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWait,
        StBurst,
        StRetry,
        StFin
    } state_e;

    // Counter width able to hold 0..max_val
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

    // Next longword of a 16-byte line: A[3:2] wraps 3->0, A[31:4] is untouched
    function automatic logic [31:0] next_beat_addr(input logic [31:0] addr);
        return {addr[31:4], addr[3:2] + 2'd1, addr[1:0]};
    endfunction

endpackage

// File: rtl/bus040_if.sv
// Request side and local bus side of the initiator, bundled for port connection.
// master = initiator view, slave = requester/responder view.
interface bus040_if;

    // Local request side
    logic        REQ;
    logic        REQ_RnW;
    logic [31:0] REQ_ADDR;
    logic [1:0]  REQ_SIZ;
    logic [31:0] WDATA;
    logic        WDATA_ACK;
    logic [31:0] RDATA;
    logic        RDATA_VLD;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic        TIMEOUT;

    // 68040-style bus side
    logic [31:0] A;
    logic        RnW;
    logic [1:0]  SIZ;
    logic        nTS;
    logic        nTIP;
    logic [31:0] D_OUT;
    logic        D_OE;
    logic [31:0] D_IN;
    logic        nTA;
    logic        nTEA;
    logic        nTBI;

    modport master (
        input  REQ, REQ_RnW, REQ_ADDR, REQ_SIZ, WDATA, D_IN, nTA, nTEA, nTBI,
        output WDATA_ACK, RDATA, RDATA_VLD, BUSY, DONE, ERR, TIMEOUT,
        output A, RnW, SIZ, nTS, nTIP, D_OUT, D_OE
    );

    modport slave (
        output REQ, REQ_RnW, REQ_ADDR, REQ_SIZ, WDATA, D_IN, nTA, nTEA, nTBI,
        input  WDATA_ACK, RDATA, RDATA_VLD, BUSY, DONE, ERR, TIMEOUT,
        input  A, RnW, SIZ, nTS, nTIP, D_OUT, D_OE
    );

endinterface

// File: rtl/bus040_watchdog.sv
// Termination watchdog: counts enabled clocks since the last clear. expired_o flags that
// the current edge is the Limit-th one without a clear; the count holds there.
module bus040_watchdog
    import bus040_pkg::*;
#(
    parameter int unsigned Limit = TIMEOUT_CYC_DEF
) (
    input  logic CLK40,
    input  logic RESET,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = cnt_width(Limit);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == CntW'(Limit - 1));

    // Clear wins over count; saturate once the limit is hit
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Counter register
    always_ff @(posedge CLK40 or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus040_initiator.sv
// 68040-style bus cycle initiator: turns a local request into TS/TIP cycles and waits for
// TA/TEA termination. Handles single cycles, 4-beat line bursts, burst-inhibit fallback to
// separate long cycles, TA+TEA retry and a no-termination watchdog. All outputs registered.
module bus040_initiator
    import bus040_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned RETRY_MAX   = RETRY_MAX_DEF
) (
    input  logic     CLK40,
    input  logic     RESET,
    bus040_if.master bus
);

    localparam int unsigned RetryW = cnt_width(RETRY_MAX);

    state_e            state_q, state_d;
    logic [31:0]       a_q, a_d;
    logic              rnw_q, rnw_d;
    logic [1:0]        siz_q, siz_d;
    logic              nts_q, nts_d;
    logic              ntip_q, ntip_d;
    logic [31:0]       d_out_q, d_out_d;
    logic              d_oe_q, d_oe_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rdata_vld_q, rdata_vld_d;
    logic              wdata_ack_q, wdata_ack_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              timeout_q, timeout_d;
    logic [1:0]        beat_q, beat_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic              line_q, line_d;
    logic              fallback_q, fallback_d;

    logic ta, tea, tbi;
    logic wd_clr, wd_en, wd_expired;
    logic beat_ok, fin_go, fin_err, fin_to;

    assign ta  = ~bus.nTA;
    assign tea = ~bus.nTEA;
    assign tbi = ~bus.nTBI;

    assign wd_en = (state_q == StStart) || (state_q == StWait) || (state_q == StBurst);

    bus040_watchdog #(
        .Limit(TIMEOUT_CYC)
    ) u_watchdog (
        .CLK40    (CLK40),
        .RESET    (RESET),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .expired_o(wd_expired)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        rnw_d       = rnw_q;
        siz_d       = siz_q;
        nts_d       = 1'b1;
        ntip_d      = ntip_q;
        d_out_d     = d_out_q;
        d_oe_d      = d_oe_q;
        rdata_d     = rdata_q;
        rdata_vld_d = 1'b0;
        wdata_ack_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        timeout_d   = timeout_q;
        beat_d      = beat_q;
        retry_d     = retry_q;
        line_d      = line_q;
        fallback_d  = fallback_q;
        wd_clr      = 1'b0;
        beat_ok     = 1'b0;
        fin_go      = 1'b0;
        fin_err     = 1'b0;
        fin_to      = 1'b0;

        // Requester presents the next write beat in the clock after WDATA_ACK
        if (wdata_ack_q) begin
            d_out_d = bus.WDATA;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.REQ) begin
                    state_d    = StStart;
                    a_d        = bus.REQ_ADDR;
                    rnw_d      = bus.REQ_RnW;
                    siz_d      = bus.REQ_SIZ;
                    line_d     = (bus.REQ_SIZ == SIZ_LINE);
                    nts_d      = 1'b0;
                    ntip_d     = 1'b0;
                    d_oe_d     = ~bus.REQ_RnW;
                    d_out_d    = bus.WDATA;
                    busy_d     = 1'b1;
                    err_d      = 1'b0;
                    timeout_d  = 1'b0;
                    beat_d     = 2'd0;
                    retry_d    = '0;
                    fallback_d = 1'b0;
                    wd_clr     = 1'b1;
                end
            end
            StStart: begin
                state_d = StWait;
            end
            StWait: begin
                if (ta && tea) begin
                    if (retry_q == RetryW'(RETRY_MAX)) begin
                        fin_go  = 1'b1;
                        fin_err = 1'b1;
                    end else begin
                        retry_d = retry_q + RetryW'(1);
                        ntip_d  = 1'b1;
                        state_d = StRetry;
                    end
                end else if (tea) begin
                    fin_go  = 1'b1;
                    fin_err = 1'b1;
                end else if (ta) begin
                    beat_ok = 1'b1;
                    if (!line_q || beat_q == 2'd3) begin
                        fin_go = 1'b1;
                    end else begin
                        beat_d = beat_q + 2'd1;
                        a_d    = next_beat_addr(a_q);
                        // Burst inhibited: finish the line as separate long cycles
                        if (fallback_q || tbi) begin
                            fallback_d = 1'b1;
                            siz_d      = SIZ_LONG;
                            nts_d      = 1'b0;
                            wd_clr     = 1'b1;
                            state_d    = StStart;
                        end else begin
                            state_d = StBurst;
                        end
                    end
                end else if (wd_expired) begin
                    fin_go  = 1'b1;
                    fin_err = 1'b1;
                    fin_to  = 1'b1;
                end
            end
            StBurst: begin
                if (tea) begin
                    fin_go  = 1'b1;
                    fin_err = 1'b1;
                end else if (ta) begin
                    beat_ok = 1'b1;
                    if (beat_q == 2'd3) begin
                        fin_go = 1'b1;
                    end else begin
                        beat_d = beat_q + 2'd1;
                        a_d    = next_beat_addr(a_q);
                    end
                end else if (wd_expired) begin
                    fin_go  = 1'b1;
                    fin_err = 1'b1;
                    fin_to  = 1'b1;
                end
            end
            StRetry: begin
                state_d = StStart;
                nts_d   = 1'b0;
                ntip_d  = 1'b0;
                wd_clr  = 1'b1;
            end
            StFin: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (beat_ok) begin
            wd_clr = 1'b1;
            if (rnw_q) begin
                rdata_d     = bus.D_IN;
                rdata_vld_d = 1'b1;
            end else begin
                wdata_ack_d = 1'b1;
            end
        end

        if (fin_go) begin
            state_d   = StFin;
            ntip_d    = 1'b1;
            d_oe_d    = 1'b0;
            done_d    = 1'b1;
            err_d     = fin_err;
            timeout_d = fin_to;
        end
    end

    // State and output registers; reset releases the bus immediately
    always_ff @(posedge CLK40 or posedge RESET) begin
        if (RESET) begin
            state_q     <= StIdle;
            a_q         <= '0;
            rnw_q       <= 1'b1;
            siz_q       <= SIZ_LONG;
            nts_q       <= 1'b1;
            ntip_q      <= 1'b1;
            d_out_q     <= '0;
            d_oe_q      <= 1'b0;
            rdata_q     <= '0;
            rdata_vld_q <= 1'b0;
            wdata_ack_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
            beat_q      <= 2'd0;
            retry_q     <= '0;
            line_q      <= 1'b0;
            fallback_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            rnw_q       <= rnw_d;
            siz_q       <= siz_d;
            nts_q       <= nts_d;
            ntip_q      <= ntip_d;
            d_out_q     <= d_out_d;
            d_oe_q      <= d_oe_d;
            rdata_q     <= rdata_d;
            rdata_vld_q <= rdata_vld_d;
            wdata_ack_q <= wdata_ack_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            timeout_q   <= timeout_d;
            beat_q      <= beat_d;
            retry_q     <= retry_d;
            line_q      <= line_d;
            fallback_q  <= fallback_d;
        end
    end

    assign bus.A         = a_q;
    assign bus.RnW       = rnw_q;
    assign bus.SIZ       = siz_q;
    assign bus.nTS       = nts_q;
    assign bus.nTIP      = ntip_q;
    assign bus.D_OUT     = d_out_q;
    assign bus.D_OE      = d_oe_q;
    assign bus.RDATA     = rdata_q;
    assign bus.RDATA_VLD = rdata_vld_q;
    assign bus.WDATA_ACK = wdata_ack_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.ERR       = err_q;
    assign bus.TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_bus040_initiator.sv
// Bench for bus040_initiator: a requester/responder model drives the interface, and a
// negedge monitor pops expected TS, read data and completion status from scoreboard queues.
module tb_bus040_initiator;
    import bus040_pkg::*;

    typedef struct packed {
        logic        rnw;
        logic [31:0] a;
        logic [31:0] wd;
    } beat_t;

    logic CLK40;
    logic RESET;

    bus040_if bus ();

    bus040_initiator #(
        .TIMEOUT_CYC(256),
        .RETRY_MAX  (3)
    ) dut (
        .CLK40(CLK40),
        .RESET(RESET),
        .bus  (bus)
    );

    initial CLK40 = 1'b0;
    always #5 CLK40 = ~CLK40;

    int n_chk = 0;
    int n_err = 0;
    int ts_cnt, rd_cnt, ack_cnt;

    logic [33:0] exp_ts[$];    // {A, SIZ} at each TS
    logic [31:0] exp_rd[$];    // RDATA at each RDATA_VLD
    logic [1:0]  exp_done[$];  // {ERR, TIMEOUT} at each DONE
    beat_t       exp_beat[$];  // bus state when a TA is presented
    logic [31:0] wq[$];        // next write beats handed over on WDATA_ACK

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic push_beat(input logic rnw, input logic [31:0] a, input logic [31:0] wd);
        beat_t b;
        b.rnw = rnw;
        b.a   = a;
        b.wd  = wd;
        exp_beat.push_back(b);
    endtask

    task automatic clear_counts();
        ts_cnt  = 0;
        rd_cnt  = 0;
        ack_cnt = 0;
    endtask

    // Called at a negedge; leaves the caller at the negedge after REQ is taken
    task automatic do_req(input logic rnw, input logic [31:0] addr, input logic [1:0] siz,
                          input logic [31:0] wd);
        bus.REQ      = 1'b1;
        bus.REQ_RnW  = rnw;
        bus.REQ_ADDR = addr;
        bus.REQ_SIZ  = siz;
        bus.WDATA    = wd;
        @(negedge CLK40);
        bus.REQ = 1'b0;
        check("busy_after_req", 64'(bus.BUSY), 64'd1);
    endtask

    task automatic wait_ts();
        int k = 0;
        while (bus.nTS !== 1'b0 && k < 20) begin
            @(negedge CLK40);
            k++;
        end
        check("ts_seen", 64'(bus.nTS), 64'd0);
    endtask

    // One responder termination, sampled by the DUT two edges after TS when called at TS
    task automatic pulse(input logic ta, input logic tea, input logic tbi);
        beat_t b;
        @(negedge CLK40);
        bus.nTA  = ~ta;
        bus.nTEA = ~tea;
        bus.nTBI = ~tbi;
        if (ta && !tea) begin
            check("beat_expected", 64'(exp_beat.size() != 0), 64'd1);
            if (exp_beat.size() != 0) begin
                b = exp_beat.pop_front();
                check("beat_addr", 64'(bus.A), 64'(b.a));
                if (!b.rnw) begin
                    check("beat_dout", 64'(bus.D_OUT), 64'(b.wd));
                    check("beat_doe", 64'(bus.D_OE), 64'd1);
                end
            end
        end
        @(negedge CLK40);
        bus.nTA  = 1'b1;
        bus.nTEA = 1'b1;
        bus.nTBI = 1'b1;
    endtask

    task automatic wait_done();
        int k = 0;
        while (bus.DONE !== 1'b1 && k < 400) begin
            @(negedge CLK40);
            k++;
        end
        check("done_seen", 64'(bus.DONE), 64'd1);
        @(negedge CLK40);
    endtask

    // Monitor / scoreboard
    initial begin
        logic [33:0] ts_e;
        logic [1:0]  dn_e;
        logic [31:0] rd_e;
        forever begin
            @(negedge CLK40);
            if (bus.nTS === 1'b0) begin
                ts_cnt++;
                check("ts_expected", 64'(exp_ts.size() != 0), 64'd1);
                if (exp_ts.size() != 0) begin
                    ts_e = exp_ts.pop_front();
                    check("ts_addr", 64'(bus.A), 64'(ts_e[33:2]));
                    check("ts_siz", 64'(bus.SIZ), 64'(ts_e[1:0]));
                end
            end
            if (bus.RDATA_VLD === 1'b1) begin
                rd_cnt++;
                check("rd_expected", 64'(exp_rd.size() != 0), 64'd1);
                if (exp_rd.size() != 0) begin
                    rd_e = exp_rd.pop_front();
                    check("rdata", 64'(bus.RDATA), 64'(rd_e));
                end
            end
            if (bus.WDATA_ACK === 1'b1) begin
                ack_cnt++;
                if (wq.size() != 0) bus.WDATA = wq.pop_front();
            end
            if (bus.DONE === 1'b1) begin
                check("done_expected", 64'(exp_done.size() != 0), 64'd1);
                if (exp_done.size() != 0) begin
                    dn_e = exp_done.pop_front();
                    check("done_err_to", 64'({bus.ERR, bus.TIMEOUT}), 64'(dn_e));
                end
            end
        end
    end

    // Hard stop if something wedges the flow
    initial begin
        #200000;
        $display("FAIL tb_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        int k;
        RESET        = 1'b1;
        bus.REQ      = 1'b0;
        bus.REQ_RnW  = 1'b1;
        bus.REQ_ADDR = '0;
        bus.REQ_SIZ  = SIZ_LONG;
        bus.WDATA    = '0;
        bus.D_IN     = '0;
        bus.nTA      = 1'b1;
        bus.nTEA     = 1'b1;
        bus.nTBI     = 1'b1;
        clear_counts();
        repeat (3) @(negedge CLK40);
        RESET = 1'b0;
        @(negedge CLK40);

        // Reset state
        check("rst_nts", 64'(bus.nTS), 64'd1);
        check("rst_ntip", 64'(bus.nTIP), 64'd1);
        check("rst_doe", 64'(bus.D_OE), 64'd0);
        check("rst_rnw", 64'(bus.RnW), 64'd1);
        check("rst_a", 64'(bus.A), 64'd0);
        check("rst_siz", 64'(bus.SIZ), 64'd0);
        check("rst_flags", 64'({bus.BUSY, bus.DONE, bus.ERR, bus.TIMEOUT}), 64'd0);
        check("rst_pulses", 64'({bus.RDATA_VLD, bus.WDATA_ACK}), 64'd0);

        // Long read, TA on the second edge after TS
        clear_counts();
        exp_ts.push_back({32'h00F8_0000, SIZ_LONG});
        push_beat(1'b1, 32'h00F8_0000, 32'h0);
        exp_rd.push_back(32'hCAFE_0001);
        exp_done.push_back(2'b00);
        bus.D_IN = 32'hCAFE_0001;
        do_req(1'b1, 32'h00F8_0000, SIZ_LONG, 32'h0);
        wait_ts();
        check("long_ntip", 64'(bus.nTIP), 64'd0);
        pulse(1'b1, 1'b0, 1'b0);
        wait_done();
        check("long_ts_cnt", 64'(ts_cnt), 64'd1);
        check("long_rd_cnt", 64'(rd_cnt), 64'd1);
        check("long_busy_low", 64'(bus.BUSY), 64'd0);
        check("long_ntip_idle", 64'(bus.nTIP), 64'd1);

        // Line write from A[3:2]=3: one TS, four beats with wrapping address
        clear_counts();
        exp_ts.push_back({32'h0000_100C, SIZ_LINE});
        push_beat(1'b0, 32'h0000_100C, 32'h1111_0000);
        push_beat(1'b0, 32'h0000_1000, 32'h2222_0001);
        push_beat(1'b0, 32'h0000_1004, 32'h3333_0002);
        push_beat(1'b0, 32'h0000_1008, 32'h4444_0003);
        wq.push_back(32'h2222_0001);
        wq.push_back(32'h3333_0002);
        wq.push_back(32'h4444_0003);
        exp_done.push_back(2'b00);
        do_req(1'b0, 32'h0000_100C, SIZ_LINE, 32'h1111_0000);
        wait_ts();
        for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0, 1'b0);
        wait_done();
        check("line_ts_cnt", 64'(ts_cnt), 64'd1);
        check("line_ack_cnt", 64'(ack_cnt), 64'd4);
        check("line_doe_off", 64'(bus.D_OE), 64'd0);

        // Line read with burst inhibit on the first TA
        clear_counts();
        exp_ts.push_back({32'h0000_2004, SIZ_LINE});
        exp_ts.push_back({32'h0000_2008, SIZ_LONG});
        exp_ts.push_back({32'h0000_200C, SIZ_LONG});
        exp_ts.push_back({32'h0000_2000, SIZ_LONG});
        push_beat(1'b1, 32'h0000_2004, 32'h0);
        push_beat(1'b1, 32'h0000_2008, 32'h0);
        push_beat(1'b1, 32'h0000_200C, 32'h0);
        push_beat(1'b1, 32'h0000_2000, 32'h0);
        for (int i = 0; i < 4; i++) exp_rd.push_back(32'hD000_0000 + 32'(i));
        exp_done.push_back(2'b00);
        do_req(1'b1, 32'h0000_2004, SIZ_LINE, 32'h0);
        for (int i = 0; i < 4; i++) begin
            wait_ts();
            bus.D_IN = 32'hD000_0000 + 32'(i);
            pulse(1'b1, 1'b0, i == 0);
        end
        wait_done();
        check("tbi_ts_cnt", 64'(ts_cnt), 64'd4);
        check("tbi_rd_cnt", 64'(rd_cnt), 64'd4);

        // TA+TEA four times: retries exhausted
        clear_counts();
        for (int i = 0; i < 4; i++) exp_ts.push_back({32'h0000_0100, SIZ_LONG});
        exp_done.push_back(2'b10);
        do_req(1'b1, 32'h0000_0100, SIZ_LONG, 32'h0);
        for (int i = 0; i < 4; i++) begin
            wait_ts();
            pulse(1'b1, 1'b1, 1'b0);
            if (i < 3) check("retry_ntip", 64'(bus.nTIP), 64'd1);
        end
        wait_done();
        check("retry_ts_cnt", 64'(ts_cnt), 64'd4);
        check("retry_rd_cnt", 64'(rd_cnt), 64'd0);

        // Byte read terminated by TEA alone
        clear_counts();
        exp_ts.push_back({32'h0000_0203, SIZ_BYTE});
        exp_done.push_back(2'b10);
        do_req(1'b1, 32'h0000_0203, SIZ_BYTE, 32'h0);
        wait_ts();
        pulse(1'b0, 1'b1, 1'b0);
        wait_done();
        check("tea_rd_cnt", 64'(rd_cnt), 64'd0);

        // Word write, single TA
        clear_counts();
        exp_ts.push_back({32'h0000_1002, SIZ_WORD});
        push_beat(1'b0, 32'h0000_1002, 32'h0000_BEEF);
        exp_done.push_back(2'b00);
        do_req(1'b0, 32'h0000_1002, SIZ_WORD, 32'h0000_BEEF);
        wait_ts();
        check("word_rnw", 64'(bus.RnW), 64'd0);
        pulse(1'b1, 1'b0, 1'b0);
        wait_done();
        check("word_ack_cnt", 64'(ack_cnt), 64'd1);

        // No termination: watchdog ends the cycle at the 256th clock after TS
        clear_counts();
        exp_ts.push_back({32'h0000_0040, SIZ_LONG});
        exp_done.push_back(2'b11);
        do_req(1'b0, 32'h0000_0040, SIZ_LONG, 32'h0000_1234);
        wait_ts();
        k = 0;
        while (bus.DONE !== 1'b1 && k < 300) begin
            @(negedge CLK40);
            k++;
        end
        check("timeout_clocks", 64'(k), 64'd256);
        check("timeout_doe", 64'(bus.D_OE), 64'd0);
        @(negedge CLK40);

        // Reset in the middle of a line write burst
        clear_counts();
        exp_ts.push_back({32'h0000_3000, SIZ_LINE});
        push_beat(1'b0, 32'h0000_3000, 32'hA000_0000);
        push_beat(1'b0, 32'h0000_3004, 32'hA000_0001);
        wq.push_back(32'hA000_0001);
        wq.push_back(32'hA000_0002);
        wq.push_back(32'hA000_0003);
        do_req(1'b0, 32'h0000_3000, SIZ_LINE, 32'hA000_0000);
        wait_ts();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        check("midburst_doe", 64'(bus.D_OE), 64'd1);
        check("midburst_ntip", 64'(bus.nTIP), 64'd0);
        RESET = 1'b1;
        #1;
        check("rst_async_nts", 64'(bus.nTS), 64'd1);
        check("rst_async_ntip", 64'(bus.nTIP), 64'd1);
        check("rst_async_doe", 64'(bus.D_OE), 64'd0);
        check("rst_async_busy", 64'(bus.BUSY), 64'd0);
        @(negedge CLK40);
        RESET = 1'b0;
        wq.delete();
        @(negedge CLK40);

        // Normal request after the abandoned burst
        clear_counts();
        exp_ts.push_back({32'h0000_0010, SIZ_LONG});
        push_beat(1'b1, 32'h0000_0010, 32'h0);
        exp_rd.push_back(32'h5A5A_00FF);
        exp_done.push_back(2'b00);
        bus.D_IN = 32'h5A5A_00FF;
        do_req(1'b1, 32'h0000_0010, SIZ_LONG, 32'h0);
        wait_ts();
        pulse(1'b1, 1'b0, 1'b0);
        wait_done();
        check("post_rst_ts_cnt", 64'(ts_cnt), 64'd1);
        check("post_rst_rd_cnt", 64'(rd_cnt), 64'd1);

        // Every expectation must have been consumed
        check("sb_ts_left", 64'(exp_ts.size()), 64'd0);
        check("sb_rd_left", 64'(exp_rd.size()), 64'd0);
        check("sb_done_left", 64'(exp_done.size()), 64'd0);
        check("sb_beat_left", 64'(exp_beat.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
